// File: rtl/mem_access_unit.sv
// mem_access_unit: MEM-stage data-memory initiator with byte enables, load formatting and stall.
// Optional access timeout is enabled by defining DM_TIMEOUT_EN.
module mem_access_unit #(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int TO_W           = 8
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        MEM_READ,
    input  logic        MEM_WRITE,
    input  logic [2:0]  MEM_FUNCT3,
    input  logic [31:0] MEM_ADDR,
    input  logic [31:0] MEM_WRITE_DATA,
    output logic [31:0] MEM_DATA_MEM_READ_DATA,
    output logic        BUSY_WAIT,
    output logic        MISALIGNED,
    output logic        ACCESS_FAULT,
    output logic        DM_READ,
    output logic        DM_WRITE,
    output logic [31:0] DM_ADDR,
    output logic [31:0] DM_WRITE_DATA,
    output logic [3:0]  DM_BYTE_EN,
    input  logic [31:0] DM_READ_DATA,
    input  logic        DM_READY
);
    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    if (2 ** TO_W <= TIMEOUT_CYCLES) begin : g_to_w_check
        $error("TO_W too narrow for TIMEOUT_CYCLES");
    end

    state_t      state_q;
    logic        rd_q, wr_q, fault_q;
    logic [31:0] addr_q, wdata_q, rdata_q;
    logic [3:0]  be_q;
    logic [2:0]  f3_q;
    logic [1:0]  lane_q;
`ifdef DM_TIMEOUT_EN
    localparam logic [TO_W-1:0] TO_LIM = TO_W'(TIMEOUT_CYCLES);
    logic [TO_W-1:0] cnt_q;
`endif

    logic        req, is_byte, is_half, mis;
    logic [3:0]  be_d;
    logic [31:0] wdata_d, ld_d;
    logic [7:0]  ld_b;
    logic [15:0] ld_h;

    assign req     = MEM_READ | MEM_WRITE;
    assign is_byte = MEM_READ ? (MEM_FUNCT3[1:0] == 2'b00) : (MEM_FUNCT3 == 3'b000);
    assign is_half = MEM_READ ? (MEM_FUNCT3[1:0] == 2'b01) : (MEM_FUNCT3 == 3'b001);
    assign mis     = is_half ? MEM_ADDR[0] : (!is_byte && MEM_ADDR[1:0] != 2'b00);

    assign MISALIGNED = (state_q == IDLE) && req && mis;
    assign BUSY_WAIT  = (state_q == ACCESS) || ((state_q == IDLE) && req && !mis);

    // Store lane enables and replicated write data from the incoming request
    always_comb begin
        be_d    = MEM_READ ? 4'b0000 : is_byte ? 4'b0001 << MEM_ADDR[1:0] :
                  is_half ? 4'b0011 << MEM_ADDR[1:0] : 4'b1111;
        wdata_d = is_byte ? {4{MEM_WRITE_DATA[7:0]}} :
                  is_half ? {2{MEM_WRITE_DATA[15:0]}} : MEM_WRITE_DATA;
    end

    // Load formatting from the latched funct3 and byte lane
    always_comb begin
        ld_b = DM_READ_DATA[{lane_q, 3'b000} +: 8];
        ld_h = lane_q[1] ? DM_READ_DATA[31:16] : DM_READ_DATA[15:0];
        ld_d = (f3_q == 3'b000) ? {{24{ld_b[7]}}, ld_b} :
               (f3_q == 3'b100) ? {24'h0, ld_b} :
               (f3_q == 3'b001) ? {{16{ld_h[15]}}, ld_h} :
               (f3_q == 3'b101) ? {16'h0, ld_h} : DM_READ_DATA;
    end

    // Access FSM with registered memory-side outputs
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q <= IDLE;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            fault_q <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            be_q    <= '0;
            f3_q    <= '0;
            lane_q  <= '0;
`ifdef DM_TIMEOUT_EN
            cnt_q   <= '0;
`endif
        end else begin
            case (state_q)
                IDLE: if (req && !mis) begin
                    addr_q  <= {MEM_ADDR[31:2], 2'b00};
                    wdata_q <= wdata_d;
                    be_q    <= be_d;
                    f3_q    <= MEM_FUNCT3;
                    lane_q  <= MEM_ADDR[1:0];
                    rd_q    <= MEM_READ;
                    wr_q    <= !MEM_READ;
`ifdef DM_TIMEOUT_EN
                    cnt_q   <= '0;
`endif
                    state_q <= ACCESS;
                end
                ACCESS: if (DM_READY) begin
                    rd_q    <= 1'b0;
                    wr_q    <= 1'b0;
                    if (rd_q) rdata_q <= ld_d;
                    state_q <= DONE;
                end
`ifdef DM_TIMEOUT_EN
                else if (cnt_q + 1'b1 == TO_LIM) begin
                    rd_q    <= 1'b0;
                    wr_q    <= 1'b0;
                    if (rd_q) rdata_q <= '0;
                    fault_q <= 1'b1;
                    state_q <= DONE;
                end else cnt_q <= cnt_q + 1'b1;
`endif
                DONE: begin
                    fault_q <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign MEM_DATA_MEM_READ_DATA = rdata_q;
    assign ACCESS_FAULT           = fault_q;
    assign DM_READ                = rd_q;
    assign DM_WRITE               = wr_q;
    assign DM_ADDR                = addr_q;
    assign DM_WRITE_DATA          = wdata_q;
    assign DM_BYTE_EN             = be_q;
endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: directed, model-checked bench for mem_access_unit (DM_TIMEOUT_EN optional).
module tb_mem_access_unit;
    localparam int TO = 4;
`ifdef DM_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic        CLK = 1'b0, RESET = 1'b0;
    logic        MEM_READ = 1'b0, MEM_WRITE = 1'b0, DM_READY = 1'b0;
    logic [2:0]  MEM_FUNCT3 = '0;
    logic [31:0] MEM_ADDR = '0, MEM_WRITE_DATA = '0, DM_READ_DATA = '0;
    logic [31:0] MEM_DATA_MEM_READ_DATA, DM_ADDR, DM_WRITE_DATA;
    logic        BUSY_WAIT, MISALIGNED, ACCESS_FAULT, DM_READ, DM_WRITE;
    logic [3:0]  DM_BYTE_EN;

    mem_access_unit #(.TIMEOUT_CYCLES(TO), .TO_W(8)) dut (
        .CLK(CLK), .RESET(RESET), .MEM_READ(MEM_READ), .MEM_WRITE(MEM_WRITE),
        .MEM_FUNCT3(MEM_FUNCT3), .MEM_ADDR(MEM_ADDR), .MEM_WRITE_DATA(MEM_WRITE_DATA),
        .MEM_DATA_MEM_READ_DATA(MEM_DATA_MEM_READ_DATA), .BUSY_WAIT(BUSY_WAIT),
        .MISALIGNED(MISALIGNED), .ACCESS_FAULT(ACCESS_FAULT), .DM_READ(DM_READ),
        .DM_WRITE(DM_WRITE), .DM_ADDR(DM_ADDR), .DM_WRITE_DATA(DM_WRITE_DATA),
        .DM_BYTE_EN(DM_BYTE_EN), .DM_READ_DATA(DM_READ_DATA), .DM_READY(DM_READY)
    );

    always #5 CLK = ~CLK;

    int n_chk = 0, n_fail = 0;
    bit chk_en = 1'b0;
    logic        e_busy = 0, e_mis = 0, e_rd = 0, e_wr = 0, e_fault = 0;
    logic [31:0] e_addr = 0, e_wd = 0, e_rdata = 0;
    logic [3:0]  e_be = 0;
    logic [31:0] cap_addr, cap_wd;
    logic [3:0]  cap_be;
    int          busy_n;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic int size_m(input logic rd, input logic [2:0] f3);
        if (rd) return (f3 == 3'd0 || f3 == 3'd4) ? 1 : (f3 == 3'd1 || f3 == 3'd5) ? 2 : 4;
        return (f3 == 3'd0) ? 1 : (f3 == 3'd1) ? 2 : 4;
    endfunction

    function automatic logic [31:0] fmt_m(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] w);
        logic [31:0] b, h;
        b = (w >> (8 * a[1:0])) & 32'hFF;
        h = (w >> (16 * a[1])) & 32'hFFFF;
        case (f3)
            3'd0: return b[7] ? (b | 32'hFFFFFF00) : b;
            3'd4: return b;
            3'd1: return h[15] ? (h | 32'hFFFF0000) : h;
            3'd5: return h;
            default: return w;
        endcase
    endfunction

    // Per-cycle comparison of every meaningful output against the model
    always @(negedge CLK) if (chk_en) begin
        chk("busy_wait", BUSY_WAIT, e_busy);
        chk("misaligned", MISALIGNED, e_mis);
        chk("dm_read", DM_READ, e_rd);
        chk("dm_write", DM_WRITE, e_wr);
        chk("access_fault", ACCESS_FAULT, e_fault);
        chk("read_data", MEM_DATA_MEM_READ_DATA, e_rdata);
        if (e_rd || e_wr) begin
            chk("dm_addr", DM_ADDR, e_addr);
            chk("dm_byte_en", DM_BYTE_EN, e_be);
        end
        if (e_wr) chk("dm_write_data", DM_WRITE_DATA, e_wd);
    end

    task automatic req(input logic rd, input logic wr, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd, input logic [31:0] word, input int rdy_at);
        int  sz, k;
        bit  m, done, to;
        busy_n = 0;
        sz = size_m(rd, f3);
        m = (a % sz) != 0;
        MEM_READ = rd; MEM_WRITE = wr; MEM_FUNCT3 = f3; MEM_ADDR = a;
        MEM_WRITE_DATA = wd; DM_READ_DATA = word; DM_READY = 1'b0;
        e_mis = m; e_busy = !m; e_rd = 0; e_wr = 0; e_fault = 0;
        #3 busy_n += int'(BUSY_WAIT);
        @(posedge CLK); #1;
        if (!m) begin
            e_mis = 0; e_busy = 1; e_rd = rd; e_wr = wr & !rd;
            e_addr = a & ~32'd3;
            e_be = rd ? 4'h0 : sz == 1 ? 4'(1 << a[1:0]) : sz == 2 ? 4'(3 << a[1:0]) : 4'hF;
            e_wd = sz == 1 ? wd[7:0] * 32'h01010101 : sz == 2 ? wd[15:0] * 32'h00010001 : wd;
            k = 1; done = 0;
            while (!done) begin
                DM_READY = (k == rdy_at);
                to = TO_EN && k == TO && !DM_READY;
                #3 busy_n += int'(BUSY_WAIT);
                if (k == 1) begin cap_addr = DM_ADDR; cap_be = DM_BYTE_EN; cap_wd = DM_WRITE_DATA; end
                @(posedge CLK); #1;
                if (DM_READY) begin
                    if (rd) e_rdata = fmt_m(f3, a, word);
                    done = 1;
                end else if (to) begin
                    if (rd) e_rdata = 0;
                    e_fault = 1;
                    done = 1;
                end else if (k >= 200) begin
                    n_chk++; n_fail++;
                    $display("FAIL access_budget: got no completion after %0d cycles, expected DM_READY", k);
                    done = 1;
                end
                k++;
            end
            DM_READY = 1'b0; e_busy = 0; e_rd = 0; e_wr = 0;
            #3 busy_n += int'(BUSY_WAIT);
            @(posedge CLK); #1;
            e_fault = 0;
        end
        MEM_READ = 0; MEM_WRITE = 0; e_mis = 0; e_busy = 0;
        @(posedge CLK); #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(posedge CLK);
        #1;
        chk("rst_dm_read", DM_READ, 0);
        chk("rst_dm_write", DM_WRITE, 0);
        chk("rst_dm_addr", DM_ADDR, 0);
        chk("rst_byte_en", DM_BYTE_EN, 0);
        chk("rst_read_data", MEM_DATA_MEM_READ_DATA, 0);
        chk("rst_busy", BUSY_WAIT, 0);
        chk("rst_fault", ACCESS_FAULT, 0);
        RESET = 1'b1;
        chk_en = 1'b1;
        @(posedge CLK); #1;

        req(1, 0, 3'd2, 32'h100, 0, 32'hDEADBEEF, 1);
        chk("lw_busy_cycles", busy_n, 2);
        chk("lw_addr", cap_addr, 32'h100);
        chk("lw_data", MEM_DATA_MEM_READ_DATA, 32'hDEADBEEF);
        req(1, 0, 3'd0, 32'h103, 0, 32'h80FF1234, 1);
        chk("lb_data", MEM_DATA_MEM_READ_DATA, 32'hFFFFFF80);
        req(1, 0, 3'd4, 32'h103, 0, 32'h80FF1234, 1);
        chk("lbu_data", MEM_DATA_MEM_READ_DATA, 32'h00000080);
        req(1, 0, 3'd1, 32'h102, 0, 32'h80FF1234, 1);
        chk("lh_data", MEM_DATA_MEM_READ_DATA, 32'hFFFF80FF);
        req(1, 0, 3'd5, 32'h102, 0, 32'h80FF1234, 1);
        chk("lhu_data", MEM_DATA_MEM_READ_DATA, 32'h000080FF);

        req(0, 1, 3'd0, 32'h201, 32'h000000A5, 0, 1);
        chk("sb_addr", cap_addr, 32'h200);
        chk("sb_be", cap_be, 4'b0010);
        chk("sb_wdata", cap_wd, 32'hA5A5A5A5);
        req(0, 1, 3'd1, 32'h202, 32'h1234BEEF, 0, 1);
        chk("sh_be", cap_be, 4'b1100);
        chk("sh_wdata", cap_wd, 32'hBEEFBEEF);
        chk("store_keeps_data", MEM_DATA_MEM_READ_DATA, 32'h000080FF);
        req(0, 1, 3'd2, 32'h204, 32'h01234567, 0, 1);
        chk("sw_be", cap_be, 4'b1111);

        req(1, 0, 3'd2, 32'h102, 0, 32'h55555555, 1);
        chk("mis_lw_busy", busy_n, 0);
        req(0, 1, 3'd1, 32'h101, 32'hFFFF, 0, 1);
        chk("mis_sh_busy", busy_n, 0);
        req(1, 0, 3'd3, 32'h101, 0, 32'h55555555, 1);
        req(1, 0, 3'd0, 32'h101, 0, 32'h0000AB00, 1);
        chk("lb_lane1", MEM_DATA_MEM_READ_DATA, 32'hFFFFFFAB);

        req(1, 1, 3'd2, 32'h10, 32'h99999999, 32'h11223344, 1);
        chk("read_wins", MEM_DATA_MEM_READ_DATA, 32'h11223344);

        req(1, 0, 3'd2, 32'h40, 0, 32'hCAFEF00D, 5);
        chk("slow_busy_cycles", busy_n, 6);
        chk("slow_data", MEM_DATA_MEM_READ_DATA, 32'hCAFEF00D);

        MEM_READ = 1; MEM_FUNCT3 = 3'd2; MEM_ADDR = 32'h300; DM_READY = 0;
        e_busy = 1;
        @(posedge CLK); #1;
        e_rd = 1; e_addr = 32'h300; e_be = 4'h0;
        @(posedge CLK); #2;
        RESET = 1'b0; MEM_READ = 0;
        e_rd = 0; e_busy = 0; e_rdata = 0;
        #1;
        chk("rst_mid_read", DM_READ, 0);
        chk("rst_mid_busy", BUSY_WAIT, 0);
        chk("rst_mid_data", MEM_DATA_MEM_READ_DATA, 0);
        @(posedge CLK); #1;
        RESET = 1'b1;
        @(posedge CLK); #1;
        req(1, 0, 3'd2, 32'h104, 0, 32'h0BADF00D, 2);
        chk("post_rst_busy", busy_n, 3);
        chk("post_rst_data", MEM_DATA_MEM_READ_DATA, 32'h0BADF00D);

        if (TO_EN) begin
            req(1, 0, 3'd2, 32'h108, 0, 32'h12345678, -1);
            chk("to_busy_cycles", busy_n, 5);
            chk("to_data", MEM_DATA_MEM_READ_DATA, 0);
            req(1, 0, 3'd2, 32'h10C, 0, 32'h87654321, TO);
            chk("to_ready_wins", MEM_DATA_MEM_READ_DATA, 32'h87654321);
        end

        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- MEM-stage data-memory initiator: takes the load/store request from EX/MEM and issues a word-aligned, byte-enabled access to data memory with a ready handshake.
- Formats load data (sign/zero extension) into MEM_DATA_MEM_READ_DATA for the MEM/WB register.
- Stalls the pipeline through BUSY_WAIT until the access completes.

Parameters:
- TIMEOUT_CYCLES, 255: max ACCESS cycles waiting for DM_READY (used only with DM_TIMEOUT_EN).
- TO_W, 8: timeout counter width; must satisfy 2^TO_W > TIMEOUT_CYCLES.

Ports:
- CLK  in  1  clock, rising edge.
- RESET  in  1  asynchronous, active-low reset.
- MEM_READ  in  1  load request.
- MEM_WRITE  in  1  store request.
- MEM_FUNCT3  in  3  RV32 load/store funct3.
- MEM_ADDR  in  32  byte address (ALU out).
- MEM_WRITE_DATA  in  32  store data, rs2.
- MEM_DATA_MEM_READ_DATA  out  32  formatted load result, registered.
- BUSY_WAIT  out  1  pipeline stall, combinational.
- MISALIGNED  out  1  misaligned-request flag, combinational.
- ACCESS_FAULT  out  1  timeout fault, registered.
- DM_READ  out  1  memory read strobe, registered.
- DM_WRITE  out  1  memory write strobe, registered.
- DM_ADDR  out  32  {addr[31:2],2'b00}, registered.
- DM_WRITE_DATA  out  32  lane-replicated store data, registered.
- DM_BYTE_EN  out  4  write byte enables, registered.
- DM_READ_DATA  in  32  memory word.
- DM_READY  in  1  access complete, sampled in ACCESS.

Behaviour:
- Reset (RESET=0, async): state IDLE; all registered outputs 0; timeout counter 0; BUSY_WAIT=0; MISALIGNED=0.
- FSM states: IDLE, ACCESS, DONE.
- IDLE, no request: all DM strobes 0, BUSY_WAIT=0.
- IDLE, aligned request (MEM_READ|MEM_WRITE):
  - BUSY_WAIT=1 in the same cycle.
  - At the next edge, latch DM_ADDR, DM_WRITE_DATA, DM_BYTE_EN and funct3, assert DM_READ or DM_WRITE, and go to ACCESS.
- IDLE, misaligned request:
  - MISALIGNED=1 combinationally; BUSY_WAIT=0; no memory access; read data register unchanged; stay IDLE.
  - Halfword is misaligned when addr[0]=1; word when addr[1:0]!=0; byte is never misaligned.
- MEM_READ and MEM_WRITE both high: read wins; write ignored.
- ACCESS:
  - BUSY_WAIT=1; strobes, address, data and enables held stable.
  - On DM_READY=1: drop strobes at that edge; if read, register the formatted data; go to DONE.
- DONE:
  - BUSY_WAIT=0 for exactly one cycle so the pipeline advances.
  - The still-presented, same request is ignored; return to IDLE.
- Latency with DM_READY in first ACCESS cycle: 2 stall cycles; data valid on MEM_DATA_MEM_READ_DATA in DONE.
- Load formatting (lane = addr[1:0]):
  - 000 LB: sign-extend byte lane.
  - 001 LH: sign-extend half selected by addr[1].
  - 010 LW: full word.
  - 100 LBU / 101 LHU: zero-extend.
  - 011/110/111: treated as LW, including the alignment check.
- Store:
  - 000 SB: DM_BYTE_EN = 0001<<lane; write data = byte replicated x4.
  - 001 SH: DM_BYTE_EN = 0011<<lane; write data = half replicated x2.
  - 010 SW and all others: DM_BYTE_EN = 1111.
- Reads: DM_BYTE_EN=0000.
- MEM_DATA_MEM_READ_DATA holds the last load result; stores and faults never alter it, except a timed-out load, which writes 0.
- RESET asserted mid-ACCESS: strobes drop immediately (async); FSM to IDLE.

Optional Feature:
- Macro: DM_TIMEOUT_EN.
- Defined:
  - Counter clears on IDLE->ACCESS and increments each ACCESS cycle without DM_READY.
  - Timeout when count reaches TIMEOUT_CYCLES: drop strobes, go to DONE, ACCESS_FAULT=1 for the DONE cycle only; a timed-out load writes 0 to MEM_DATA_MEM_READ_DATA.
  - DM_READY in the same cycle as the timeout wins: normal completion, no fault.
- Undefined: no counter; ACCESS waits indefinitely; ACCESS_FAULT tied 0.

Test Plan:
- LW, addr 0x100, DM_READ_DATA=0xDEADBEEF, DM_READY in first ACCESS cycle -> DM_READ high 1 cycle, DM_ADDR=0x100, BUSY_WAIT high 2 cycles, DONE output 0xDEADBEEF.
- LB addr 0x103 with word 0x80FF1234 -> 0xFFFFFF80; LBU same -> 0x00000080; LH addr 0x102 -> 0xFFFF80FF; LHU -> 0x000080FF.
- SB addr 0x201, data 0x000000A5 -> DM_ADDR=0x200, DM_BYTE_EN=0010, DM_WRITE_DATA=0xA5A5A5A5; SH addr 0x202 -> BYTE_EN=1100; prior load value unchanged.
- LW addr 0x102 and SH addr 0x101 -> MISALIGNED=1 same cycle, BUSY_WAIT=0, DM_READ/DM_WRITE stay 0.
- DM_READY delayed 5 cycles -> BUSY_WAIT high 6 cycles, strobes/address stable throughout; RESET low during ACCESS -> strobes 0 immediately, IDLE after release.
- DM_TIMEOUT_EN, TIMEOUT_CYCLES=4, DM_READY never asserted on LW -> strobes drop after 4 ACCESS cycles, ACCESS_FAULT pulses 1 cycle, read data 0.
